// File: rtl/bcd_conv_pkg.sv
// Shared constants and tag type for the BCD converter scheduler.
// BCD_CONV_OVF_EN adds the overflow flag to the tag.
package bcd_conv_pkg;

  localparam int          CONV_LAT_DEF = 3;
  localparam logic [15:0] BCD_MAX      = 16'd9999;
  localparam int          TAG_IDW      = 3;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
    logic               neg;
`ifdef BCD_CONV_OVF_EN
    logic               ovf;
`endif
  } tag_t;

  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, combinational one-hot grant; pointer moves past each winner.
// Grant is forced low and the pointer cleared while rst is high.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // Scan from the pointer upward, wrapping; first active request wins.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
      end
    end
    if (rst) begin
      gnt   = '0;
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Shares one pipelined bin-to-BCD converter among NREQ requesters; result CONV_LAT+1 cycles after grant.
// No stall: one grant per cycle, results in grant order. BCD_CONV_OVF_EN enables the overflow flag.
module bcd_conv_sched
  import bcd_conv_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int CONV_LAT = CONV_LAT_DEF,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_val,
  output logic [NREQ-1:0]      gnt,
  output logic                 conv_wr,
  output logic [15:0]          conv_hex,
  input  logic [15:0]          conv_dec,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_dec,
  output logic                 rsp_neg,
  output logic                 rsp_ovf
);

  logic [IDW-1:0] gnt_id;
  tag_t           tag_d;
  tag_t           tag_q [1:CONV_LAT];
  tag_t           tag_out;

  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [15:0]    rsp_dec_q;
  logic           rsp_neg_q;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  always_comb begin
    gnt_id   = '0;
    conv_hex = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_id   = IDW'(i);
        conv_hex = req_val[16*i +: 16];
      end
    end
  end

  assign conv_wr = |gnt;

  always_comb begin
    tag_d       = '0;
    tag_d.valid = conv_wr;
    tag_d.id    = TAG_IDW'(gnt_id);
    tag_d.neg   = conv_hex[15];
`ifdef BCD_CONV_OVF_EN
    tag_d.ovf   = conv_wr && (abs16(conv_hex) > BCD_MAX);
`endif
  end

  // Stage k holds the tag of the conversion written k edges ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= CONV_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[1] <= tag_d;
      for (int k = 2; k <= CONV_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tag_out = tag_q[CONV_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_dec_q   <= '0;
      rsp_neg_q   <= 1'b0;
    end else begin
      rsp_valid_q <= tag_out.valid;
      if (tag_out.valid) begin
        rsp_id_q  <= IDW'(tag_out.id);
        rsp_dec_q <= conv_dec;
        rsp_neg_q <= tag_out.neg;
      end
    end
  end

`ifdef BCD_CONV_OVF_EN
  logic rsp_ovf_q;

  always_ff @(posedge clk) begin
    if (rst)                rsp_ovf_q <= 1'b0;
    else if (tag_out.valid) rsp_ovf_q <= tag_out.ovf;
  end

  assign rsp_ovf = rsp_ovf_q;
`else
  assign rsp_ovf = 1'b0;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_dec   = rsp_dec_q;
  assign rsp_neg   = rsp_neg_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched with a behavioural converter and a reference round-robin model.
module tb_bcd_conv_sched;

  localparam int NREQ     = 4;
  localparam int CONV_LAT = 3;
  localparam int IDW      = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [16*NREQ-1:0]  req_val;
  logic [NREQ-1:0]     gnt;
  logic                conv_wr;
  logic [15:0]         conv_hex;
  logic [15:0]         conv_dec;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [15:0]         rsp_dec;
  logic                rsp_neg;
  logic                rsp_ovf;

  typedef struct {
    int          id;
    logic [15:0] dec;
    logic        neg;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t            sb[$];
  logic [15:0]     vq[NREQ][$];
  int              glog[$];
  int              gcyc[$];
  int              rsp_cnt[NREQ];
  logic [NREQ-1:0] granted_last = '0;
  int              tb_ptr = 0;
  int              cyc = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  logic [15:0]     cpipe[CONV_LAT];

  bcd_conv_sched #(.NREQ(NREQ), .CONV_LAT(CONV_LAT), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_val   (req_val),
    .gnt       (gnt),
    .conv_wr   (conv_wr),
    .conv_hex  (conv_hex),
    .conv_dec  (conv_dec),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_dec   (rsp_dec),
    .rsp_neg   (rsp_neg),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int mag_of(input logic [15:0] v);
    return v[15] ? 65536 - int'(v) : int'(v);
  endfunction

  // Behavioural converter: lower four decimal digits of the magnitude.
  function automatic logic [15:0] bcd_of(input logic [15:0] v);
    int m;
    m = mag_of(v) % 10000;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  always @(posedge clk) begin
    cpipe[0] <= bcd_of(conv_hex);
    for (int k = 1; k < CONV_LAT; k++) cpipe[k] <= cpipe[k-1];
  end
  assign conv_dec = cpipe[CONV_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void refresh();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (vq[i].size() > 0);
      req_val[16*i +: 16] = req[i] ? vq[i][0] : 16'h0;
    end
  endfunction

  task automatic send(input int i, input logic [15:0] v);
    vq[i].push_back(v);
    refresh();
  endtask

  // Requesters: drop the head value after its grant, re-request with the next one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (granted_last[i]) void'(vq[i].pop_front());
      granted_last = '0;
      refresh();
    end
  end

  // Monitor: responses against the scoreboard, grants against the reference arbiter.
  initial begin
    exp_t            e;
    int              eg;
    int              idx;
    logic [NREQ-1:0] eg_oh;
    logic [15:0]     v;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id",  32'(rsp_id),  32'(e.id));
          chk("rsp_dec", 32'(rsp_dec), 32'(e.dec));
          chk("rsp_neg", 32'(rsp_neg), 32'(e.neg));
          chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
          chk("rsp_lat", 32'(cyc - e.cyc), 32'(CONV_LAT + 1));
          rsp_cnt[e.id]++;
        end
      end
      if (rst) begin
        chk("rst_gnt", 32'({conv_wr, gnt}), 32'd0);
        chk("rst_hex", 32'(conv_hex), 32'd0);
        sb.delete();
        tb_ptr = 0;
      end else begin
        eg = -1;
        eg_oh = '0;
        for (int k = 0; k < NREQ; k++) begin
          idx = (tb_ptr + k) % NREQ;
          if (eg < 0 && req[idx]) eg = idx;
        end
        if (eg >= 0) eg_oh[eg] = 1'b1;
        chk("gnt",     32'(gnt),     32'(eg_oh));
        chk("conv_wr", 32'(conv_wr), 32'(eg >= 0));
        granted_last = gnt;
        if (eg >= 0) begin
          v = req_val[16*eg +: 16];
          chk("conv_hex", 32'(conv_hex), 32'(v));
          e.id  = eg;
          e.dec = bcd_of(v);
          e.neg = v[15];
`ifdef BCD_CONV_OVF_EN
          e.ovf = (mag_of(v) > 9999);
`else
          e.ovf = 1'b0;
`endif
          e.cyc = cyc;
          sb.push_back(e);
          glog.push_back(eg);
          gcyc.push_back(cyc);
          tb_ptr = (eg + 1) % NREQ;
        end else begin
          chk("conv_hex_idle", 32'(conv_hex), 32'd0);
        end
      end
    end
  end

  task automatic drain();
    int n;
    int busy;
    n = 0;
    busy = 1;
    while (busy != 0 && n < 300) begin
      busy = (sb.size() != 0);
      for (int i = 0; i < NREQ; i++) if (vq[i].size() != 0) busy = 1;
      if (busy != 0) begin
        @(posedge clk);
        n++;
      end
    end
    if (n >= 300) chk("drain_timeout", 32'(n), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    glog.delete();
    gcyc.delete();
    for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_val = '0;
    for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;
    send(1, 16'd5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_id",    32'(rsp_id),    32'd0);
    chk("reset_dec",   32'(rsp_dec),   32'd0);
    chk("reset_neg",   32'(rsp_neg),   32'd0);
    chk("reset_ovf",   32'(rsp_ovf),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drain();

    @(posedge clk); #2;
    send(0, 16'h04D2);
    drain();
    chk("pos_dec", 32'(rsp_dec), 32'h1234);
    chk("pos_neg", 32'(rsp_neg), 32'd0);
    chk("pos_id",  32'(rsp_id),  32'd0);

    @(posedge clk); #2;
    send(2, 16'hFB2E);
    drain();
    chk("neg_dec", 32'(rsp_dec), 32'h1234);
    chk("neg_neg", 32'(rsp_neg), 32'd1);
    chk("neg_id",  32'(rsp_id),  32'd2);

    @(posedge clk); #2;
    send(3, 16'h2710);
    send(3, 16'h8000);
    drain();
`ifdef BCD_CONV_OVF_EN
    chk("ovf_flag", 32'(rsp_ovf), 32'd1);
`else
    chk("ovf_flag", 32'(rsp_ovf), 32'd0);
`endif
    chk("ovf_neg", 32'(rsp_neg), 32'd1);

    @(posedge clk); #2;
    send(1, 16'hD8F1);
    drain();
    chk("max_dec", 32'(rsp_dec), 32'h9999);
    chk("max_ovf", 32'(rsp_ovf), 32'd0);
    chk("max_neg", 32'(rsp_neg), 32'd1);

    @(posedge clk); #2;
    send(0, 16'd42);
    drain();
    clear_logs();
    @(posedge clk); #2;
    send(0, 16'd100);
    send(1, 16'd201);
    send(3, 16'd303);
    drain();
    chk("rr_count", 32'(glog.size()), 32'd3);
    if (glog.size() == 3) begin
      chk("rr_first",  32'(glog[0]), 32'd1);
      chk("rr_second", 32'(glog[1]), 32'd3);
      chk("rr_third",  32'(glog[2]), 32'd0);
      chk("rr_span",   32'(gcyc[2] - gcyc[0]), 32'd2);
    end

    clear_logs();
    @(posedge clk); #2;
    send(1, 16'd11);
    send(2, 16'd22);
    send(3, 16'd33);
    @(posedge clk); #2;
    vq[2].delete();
    refresh();
    drain();
    chk("skip_count", 32'(glog.size()), 32'd2);
    chk("skip_req2",  32'(rsp_cnt[2]),  32'd0);

    clear_logs();
    @(posedge clk); #2;
    send(1, 16'd777);
    send(2, 16'd888);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(rsp_valid), 32'd0);
    chk("flush_id",    32'(rsp_id),    32'd0);
    chk("flush_dec",   32'(rsp_dec),   32'd0);
    chk("flush_neg",   32'(rsp_neg),   32'd0);
    chk("flush_hex",   32'(conv_hex),  32'd0);
    repeat (4) @(posedge clk);
    chk("flush_rsp", 32'(rsp_cnt[1] + rsp_cnt[2]), 32'd0);
    clear_logs();
    #2;
    send(3, 16'd3);
    send(1, 16'd1);
    drain();
    chk("post_rst_cnt", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) chk("post_rst_first", 32'(glog[0]), 32'd1);

    clear_logs();
    @(posedge clk); #2;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < NREQ; i++) send(i, 16'($urandom_range(0, 65535)));
    drain();
    chk("sust_grants", 32'(glog.size()), 32'd16);
    if (gcyc.size() == 16) chk("sust_span", 32'(gcyc[15] - gcyc[0]), 32'd15);
    for (int i = 0; i < NREQ; i++) chk("sust_per_req", 32'(rsp_cnt[i]), 32'd4);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
